led_chaser: RTL and testbench

//   Free-running LED "chaser" for the board-level top. An 8-bit one-hot ring

---
 rtl/led_chaser.sv | 44 ++++
 tb/tb_led_chaser.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/led_chaser.sv
// Free-running LED chaser: a one-hot byte rotates left once per prescaler
// period on the upper LED byte, and the slide switches drive the lower byte directly.
module led_chaser #(
    parameter int unsigned DIV_MAX = 5000000,
    parameter int unsigned CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sw,
    output logic [15:0] ledr
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       ring_q;
    logic [7:0]       ring_d;

    // The ring steps on the edge where cnt is 0. Because cnt resets to 0,
    // the first step happens on the first edge after reset is released.
    // The >= compare brings any out-of-range count back to 0 in one cycle.
    always_comb begin
        cnt_d  = (cnt_q >= CNT_W'(DIV_MAX)) ? '0 : cnt_q + CNT_W'(1);
        ring_d = (cnt_q == '0) ? {ring_q[6:0], ring_q[7]} : ring_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            ring_q <= 8'h01;
        end else begin
            cnt_q  <= cnt_d;
            ring_q <= ring_d;
        end
    end

    assign ledr[15:8] = ring_q;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_sw
            assign ledr[gi] = sw[gi];
        end
    endgenerate

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser: one instance with DIV_MAX=3 and one with DIV_MAX=0, both on shared inputs.
// It uses table vectors, hand-written corner sequences and a randomized run against an edge-count model.
module tb_led_chaser;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  sw  = 8'h00;
    logic [15:0] ledr_a;
    logic [15:0] ledr_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int k      = 0;   // non-reset edges since the last reset edge

    always #5 clk = ~clk;

    led_chaser #(.DIV_MAX(3), .CNT_W(32)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .ledr (ledr_a)
    );

    led_chaser #(.DIV_MAX(0), .CNT_W(32)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .sw   (sw),
        .ledr (ledr_b)
    );

    // After k free edges the ring has made ceil(k/(div+1)) rotations.
    function automatic logic [7:0] ring_model(input int kk, input int div);
        int rot;
        rot = (kk + div) / (div + 1);
        return 8'h01 << (rot % 8);
    endfunction

    task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic check_all(input string tag);
        cmp16({tag, "/div3"}, ledr_a, {ring_model(k, 3), sw});
        cmp16({tag, "/div0"}, ledr_b, {ring_model(k, 0), sw});
        n_cmp++;
        if (!$onehot(ledr_a[15:8]) || !$onehot(ledr_b[15:8])) begin
            n_fail++;
            $display("FAIL %s/onehot: got %h / %h expected one-hot", tag, ledr_a[15:8], ledr_b[15:8]);
        end
        cmp16({tag, "/cnt"}, dut_a.cnt_q[15:0], 16'(k % 4));
    endtask

    task automatic tick(input logic r, input logic [7:0] s);
        rst = r;
        sw  = s;
        @(posedge clk);
        k = r ? 0 : k + 1;
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] sw;
        logic [7:0] exp_ring;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [7:0] sw_vals[3];
        int guard;

        vecs[0]  = '{1'b1, 8'h00, 8'h01};
        vecs[1]  = '{1'b1, 8'h3C, 8'h01};
        vecs[2]  = '{1'b0, 8'h00, 8'h02};
        vecs[3]  = '{1'b0, 8'hA5, 8'h02};
        vecs[4]  = '{1'b0, 8'hFF, 8'h02};
        vecs[5]  = '{1'b0, 8'h00, 8'h02};
        vecs[6]  = '{1'b0, 8'h5A, 8'h04};
        vecs[7]  = '{1'b0, 8'h01, 8'h04};
        vecs[8]  = '{1'b0, 8'h80, 8'h04};
        vecs[9]  = '{1'b0, 8'h00, 8'h04};
        vecs[10] = '{1'b0, 8'h11, 8'h08};

        // Reset, release, and the first three ring values taken from the table.
        for (int i = 0; i < 11; i++) begin
            tick(vecs[i].rst, vecs[i].sw);
            $display("vec %0d: rst=%0b sw=%h ledr=%h", i, vecs[i].rst, vecs[i].sw, ledr_a);
            cmp16($sformatf("vec%0d", i), ledr_a, {vecs[i].exp_ring, vecs[i].sw});
            check_all($sformatf("vec%0d", i));
        end

        // Run eight more periods; this covers the 80 -> 01 wrap.
        for (int i = 0; i < 32; i++) begin
            tick(1'b0, 8'(i));
            check_all("wrap");
        end
        $display("wrap run done: ledr=%h", ledr_a);

        // The switches pass through in the same cycle, mid-period and during reset.
        sw_vals[0] = 8'h00; sw_vals[1] = 8'hA5; sw_vals[2] = 8'hFF;
        for (int r = 0; r < 2; r++) begin
            if (r == 1) tick(1'b1, 8'h00);
            for (int i = 0; i < 3; i++) begin
                sw = sw_vals[i];
                #1;
                $display("sw pass: rst=%0b sw=%h ledr=%h", rst, sw, ledr_a);
                check_all(r == 1 ? "sw_rst" : "sw_mid");
            end
        end
        tick(1'b0, 8'h00);
        check_all("rel");

        // Apply reset while the ring shows 8'h20, then release it.
        guard = 0;
        while (ring_model(k, 3) != 8'h20 && guard < 100) begin
            tick(1'b0, 8'h42);
            guard++;
        end
        cmp16("reach20", {8'h00, ledr_a[15:8]}, 16'h0020);
        tick(1'b1, 8'h42);
        cmp16("rst_at20", ledr_a, 16'h0142);
        check_all("rst_at20");
        tick(1'b0, 8'h42);
        cmp16("after_rel", ledr_a, 16'h0242);
        check_all("after_rel");

        // Randomized run with occasional resets.
        for (int i = 0; i < 400; i++) begin
            logic r;
            r = ($urandom_range(0, 19) == 0);
            tick(r, 8'($urandom));
            $display("rand %0d: rst=%0b sw=%h ledr_a=%h ledr_b=%h", i, r, sw, ledr_a, ledr_b);
            check_all("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
